fibo_seq: RTL and testbench

- Fibonacci sequence controller that sits directly upstream of the two-operand adder stage and drives its A/B operands and IEA/IEB load strobes.
- Consumes the adder's Y/OE result, keeps the last two terms, and streams F(0)..F(N-1) to the consumer one term at a time.
- Flags unsigned wrap-around of the BITS-wide sum.

---
 rtl/fibo_seq_if.sv | 42 ++++
 rtl/fibo_seq.sv | 176 +++++++++++++++++
 tb/tb_fibo_seq.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fibo_seq_if.sv
// rtl/fibo_seq_if.sv - request/result and adder-operand bundle for fibo_seq
//
// Purpose: groups the sequence request/term stream and the adder operand/result
// wires so the controller, the adder and the consumer share one connection.
// Signals:
//   START, N             request side: begin a run of N terms
//   BUSY, DONE           run status (DONE is a single-cycle pulse)
//   TERM, IDX, TERM_VALID, OVF   emitted term stream and sticky wrap flag
//   ADD_A, ADD_B, ADD_IEA, ADD_IEB   operands and load strobes to the adder
//   ADD_Y, ADD_OE        sum and result-valid from the adder
// Modports: slave = the fibo_seq controller, master = its environment.
interface fibo_seq_if #(
    parameter int BITS = 32,
    parameter int NW   = 8
);
    logic            START;
    logic [NW-1:0]   N;
    logic            BUSY;
    logic            DONE;
    logic [BITS-1:0] TERM;
    logic            TERM_VALID;
    logic [NW-1:0]   IDX;
    logic            OVF;
    logic [BITS-1:0] ADD_A;
    logic [BITS-1:0] ADD_B;
    logic            ADD_IEA;
    logic            ADD_IEB;
    logic [BITS-1:0] ADD_Y;
    logic            ADD_OE;

    modport slave (
        input  START, N, ADD_Y, ADD_OE,
        output BUSY, DONE, TERM, TERM_VALID, IDX, OVF,
               ADD_A, ADD_B, ADD_IEA, ADD_IEB
    );

    modport master (
        output START, N, ADD_Y, ADD_OE,
        input  BUSY, DONE, TERM, TERM_VALID, IDX, OVF,
               ADD_A, ADD_B, ADD_IEA, ADD_IEB
    );
endinterface

// File: rtl/fibo_seq.sv
// rtl/fibo_seq.sv - Fibonacci sequence controller driving an external two-operand adder
//
// Purpose: emits F(0)..F(N-1) one term per TERM_VALID pulse. F(0) and F(1) are
// produced directly; every later term is obtained by loading the previous two
// terms into the adder and capturing its sum once per ADD_OE high period.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    fibo_seq_if.slave: START/N in, BUSY/DONE/TERM/TERM_VALID/IDX/OVF out,
//          ADD_A/ADD_B/ADD_IEA/ADD_IEB out to the adder, ADD_Y/ADD_OE in from it
// All outputs are registered.
module fibo_seq #(
    parameter int BITS = 32,
    parameter int NW   = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    fibo_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT0,
        S_EMIT1,
        S_ISSUE,
        S_WAITOE,
        S_WAITCLR,
        S_FIN
    } state_t;

    state_t          state_q;
    logic [NW-1:0]   n_q;
    // Index of the next term to emit; equals n_q once every term is out.
    logic [NW-1:0]   count_q;
    logic [BITS-1:0] r0_q;
    logic [BITS-1:0] r1_q;

    logic            busy_q;
    logic            done_q;
    logic [BITS-1:0] term_q;
    logic            term_valid_q;
    logic [NW-1:0]   idx_q;
    logic            ovf_q;
    logic [BITS-1:0] add_a_q;
    logic [BITS-1:0] add_b_q;
    // A single strobe register feeds both IEA and IEB so they can never differ.
    logic            add_ie_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            count_q      <= '0;
            r0_q         <= '0;
            r1_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            term_q       <= '0;
            term_valid_q <= 1'b0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_ie_q     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            done_q       <= 1'b0;
            term_valid_q <= 1'b0;
            add_ie_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        n_q    <= bus.N;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.N == '0) begin
                            // DONE is raised on entry so it coincides with FIN,
                            // the last cycle BUSY is high.
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_EMIT0;
                        end
                    end
                end

                S_EMIT0: begin
                    term_q       <= '0;
                    idx_q        <= '0;
                    term_valid_q <= 1'b1;
                    r0_q         <= '0;
                    if (n_q == NW'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        state_q <= S_EMIT1;
                    end
                end

                S_EMIT1: begin
                    term_q       <= BITS'(1);
                    idx_q        <= NW'(1);
                    term_valid_q <= 1'b1;
                    r1_q         <= BITS'(1);
                    count_q      <= NW'(2);
                    if (n_q == NW'(2)) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        // Go through WAITCLR so a stale OE left high by the
                        // unreset adder is drained before the first ISSUE.
                        state_q <= S_WAITCLR;
                    end
                end

                S_ISSUE: begin
                    add_a_q  <= r0_q;
                    add_b_q  <= r1_q;
                    add_ie_q <= 1'b1;
                    state_q  <= S_WAITOE;
                end

                S_WAITOE: begin
                    if (bus.ADD_OE) begin
                        term_q       <= bus.ADD_Y;
                        idx_q        <= count_q;
                        term_valid_q <= 1'b1;
                        r0_q         <= r1_q;
                        r1_q         <= bus.ADD_Y;
                        count_q      <= count_q + NW'(1);
                        // A sum smaller than an addend means it wrapped.
                        if (bus.ADD_Y < r1_q) begin
                            ovf_q <= 1'b1;
                        end
                        state_q <= S_WAITCLR;
                    end
                end

                S_WAITCLR: begin
                    // The adder holds OE for two cycles; waiting for it to drop
                    // gives exactly one capture per OE high period.
                    if (!bus.ADD_OE) begin
                        if (count_q == n_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end

                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.TERM       = term_q;
    assign bus.TERM_VALID = term_valid_q;
    assign bus.IDX        = idx_q;
    assign bus.OVF        = ovf_q;
    assign bus.ADD_A      = add_a_q;
    assign bus.ADD_B      = add_b_q;
    assign bus.ADD_IEA    = add_ie_q;
    assign bus.ADD_IEB    = add_ie_q;

endmodule

// File: tb/tb_fibo_seq.sv
// tb/tb_fibo_seq.sv - directed self-checking bench for fibo_seq with adder models
module tb_fibo_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc;

    fibo_seq_if #(.BITS(32), .NW(8)) bus ();
    fibo_seq_if #(.BITS(8),  .NW(8)) bus8 ();

    fibo_seq #(.BITS(32), .NW(8)) dut  (.CLK(clk), .RST_N(rst_n), .bus(bus));
    fibo_seq #(.BITS(8),  .NW(8)) dut8 (.CLK(clk), .RST_N(rst_n), .bus(bus8));

    // Adder models: no reset, start with stale OE high, OE high 2 cycles after load.
    logic [1:0]  oe_cnt  = 2'd2;
    logic [31:0] add_y   = 32'hDEAD_BEEF;
    logic [1:0]  oe_cnt8 = 2'd2;
    logic [7:0]  add_y8  = 8'hA5;

    always @(posedge clk) begin
        if (bus.ADD_IEA && bus.ADD_IEB) begin
            add_y  <= bus.ADD_A + bus.ADD_B;
            oe_cnt <= 2'd2;
        end else if (oe_cnt != 2'd0) begin
            oe_cnt <= oe_cnt - 2'd1;
        end
        if (bus8.ADD_IEA && bus8.ADD_IEB) begin
            add_y8  <= bus8.ADD_A + bus8.ADD_B;
            oe_cnt8 <= 2'd2;
        end else if (oe_cnt8 != 2'd0) begin
            oe_cnt8 <= oe_cnt8 - 2'd1;
        end
    end
    assign bus.ADD_Y   = add_y;
    assign bus.ADD_OE  = (oe_cnt != 2'd0);
    assign bus8.ADD_Y  = add_y8;
    assign bus8.ADD_OE = (oe_cnt8 != 2'd0);

    always @(posedge clk) cyc <= cyc + 1;

    // Observation records, sampled on the falling edge.
    logic [31:0] tq[$];
    int          iq[$];
    logic        oq[$];
    int          tcq[$];
    int          ieq[$];
    int          doneq[$];
    int          ie_bad, ab_bad, busy_cyc;
    logic [31:0] p1, p2;
    logic        ie_prev;
    logic [7:0]  t8q[$];
    logic        o8q[$];

    always @(negedge clk) begin
        if (bus.ADD_IEA === 1'b1 || bus.ADD_IEB === 1'b1) begin
            ieq.push_back(cyc);
            if (bus.ADD_IEA !== bus.ADD_IEB || ie_prev) ie_bad++;
            if (bus.ADD_A !== p2 || bus.ADD_B !== p1) ab_bad++;
        end
        ie_prev = (bus.ADD_IEA === 1'b1 || bus.ADD_IEB === 1'b1);
        if (bus.TERM_VALID === 1'b1) begin
            tq.push_back(bus.TERM);
            iq.push_back(int'(bus.IDX));
            oq.push_back(bus.OVF);
            tcq.push_back(cyc);
            p2 = p1;
            p1 = bus.TERM;
        end
        if (bus.DONE === 1'b1) doneq.push_back(cyc);
        if (bus.BUSY === 1'b1) busy_cyc++;
        if (bus8.TERM_VALID === 1'b1) begin
            t8q.push_back(bus8.TERM);
            o8q.push_back(bus8.OVF);
        end
    end

    logic [31:0] exp10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    logic [7:0]  exp8  [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};

    task automatic clear_mon();
        tq.delete(); iq.delete(); oq.delete(); tcq.delete();
        ieq.delete(); doneq.delete(); t8q.delete(); o8q.delete();
        ie_bad = 0; ab_bad = 0; busy_cyc = 0;
        p1 = '0; p2 = '0; ie_prev = 1'b0;
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        bus.START = 1'b1;
        bus.N     = n[7:0];
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_seq10(input string tag);
        checks++;
        if (tq.size() !== 10) begin
            errors++;
            $display("FAIL %s term_count: got %0d want 10", tag, tq.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (tq[k] !== exp10[k] || iq[k] !== k) begin
                    errors++;
                    $display("FAIL %s term%0d: got %0d@%0d want %0d@%0d", tag, k, tq[k], iq[k], exp10[k], k);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        bus.START = 1'b0; bus.N = '0; bus8.START = 1'b0; bus8.N = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.TERM, bus.TERM_VALID, bus.IDX, bus.OVF,
             bus.ADD_A, bus.ADD_B, bus.ADD_IEA, bus.ADD_IEB} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b term=%h idx=%0d a=%h b=%h ie=%b%b want all 0",
                     bus.BUSY, bus.TERM, bus.IDX, bus.ADD_A, bus.ADD_B, bus.ADD_IEA, bus.ADD_IEB);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_n10();
        bit ok;
        clear_mon();
        start_run(10);
        wait_done(200, ok);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL n10_done_timeout: got no DONE want DONE"); end
        check_seq10("n10");
        checks++;
        if (doneq.size() !== 1 || doneq[0] - start_cyc !== 44) begin
            errors++;
            $display("FAIL n10_done_latency: got %0d pulses latency %0d want 1 pulse latency 44",
                     doneq.size(), doneq.size() ? doneq[0] - start_cyc : -1);
        end
        checks++;
        if (tcq.size() == 10 && tcq[9] - start_cyc !== 42) begin
            errors++;
            $display("FAIL n10_last_term_cycle: got %0d want 42", tcq[9] - start_cyc);
        end
        checks++;
        if (busy_cyc !== 44) begin
            errors++;
            $display("FAIL n10_busy_cycles: got %0d want 44", busy_cyc);
        end
        checks++;
        if (bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL n10_ovf: got %b want 0", bus.OVF);
        end
        checks++;
        if (ieq.size() !== 8) begin
            errors++;
            $display("FAIL n10_issue_count: got %0d want 8", ieq.size());
        end else begin
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (ieq[k] - ieq[k-1] !== 5) begin
                    errors++;
                    $display("FAIL n10_issue_spacing%0d: got %0d want 5", k, ieq[k] - ieq[k-1]);
                end
            end
        end
        checks++;
        if (ie_bad !== 0 || ab_bad !== 0) begin
            errors++;
            $display("FAIL n10_strobes: got ie_bad=%0d ab_bad=%0d want 0/0", ie_bad, ab_bad);
        end
    endtask

    task automatic test_short();
        bit ok;
        for (int n = 0; n <= 2; n++) begin
            clear_mon();
            start_run(n);
            wait_done(20, ok);
            @(negedge clk);
            checks++;
            if (!ok || doneq.size() !== 1 || doneq[0] - start_cyc !== n + 1) begin
                errors++;
                $display("FAIL short%0d_done: got ok=%b pulses=%0d want 1 pulse at +%0d", n, ok, doneq.size(), n + 1);
            end
            checks++;
            if (tq.size() !== n || busy_cyc !== n + 1) begin
                errors++;
                $display("FAIL short%0d_terms_busy: got terms=%0d busy=%0d want %0d/%0d", n, tq.size(), busy_cyc, n, n + 1);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (tq[k] !== 32'(k) || iq[k] !== k) begin
                        errors++;
                        $display("FAIL short%0d_term%0d: got %0d want %0d", n, k, tq[k], k);
                    end
                end
            end
            checks++;
            if (ieq.size() !== 0) begin
                errors++;
                $display("FAIL short%0d_no_issue: got %0d strobes want 0", n, ieq.size());
            end
        end
    endtask

    task automatic test_wrap8();
        bit ok;
        clear_mon();
        @(posedge clk); #1 bus8.START = 1'b1; bus8.N = 8'd16;
        @(posedge clk); #1 bus8.START = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus8.DONE === 1'b1) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        checks++;
        if (!ok || t8q.size() !== 16) begin
            errors++;
            $display("FAIL wrap_run: got done=%b terms=%0d want 1/16", ok, t8q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (t8q[k] !== exp8[k] || o8q[k] !== (k >= 14)) begin
                    errors++;
                    $display("FAIL wrap_term%0d: got %0d ovf=%b want %0d ovf=%b", k, t8q[k], o8q[k], exp8[k], k >= 14);
                end
            end
        end
        checks++;
        if (bus8.OVF !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf_sticky: got %b want 1", bus8.OVF);
        end
        @(posedge clk); #1 bus8.START = 1'b1; bus8.N = 8'd1;
        @(posedge clk); #1 bus8.START = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus8.OVF !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf_clear: got %b want 0", bus8.OVF);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit seen;
        clear_mon();
        start_run(10);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.TERM_VALID === 1'b1 && bus.IDX === 8'd4) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL ign_idx4_timeout: got no IDX 4 want IDX 4"); end
        @(posedge clk); #1 bus.START = 1'b1; bus.N = 8'd3;
        @(posedge clk); #1 bus.START = 1'b0;
        wait_done(200, ok);
        @(negedge clk);
        check_seq10("ign");
        checks++;
        if (!ok || doneq.size() !== 1 || doneq[0] - start_cyc !== 44) begin
            errors++;
            $display("FAIL ign_done: got ok=%b pulses=%0d want 1 pulse at +44", ok, doneq.size());
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || tq.size() !== 10) begin
            errors++;
            $display("FAIL ign_no_restart: got busy=%b terms=%0d want 0/10", bus.BUSY, tq.size());
        end
    endtask

    task automatic test_start_held();
        bit ok1, ok2;
        clear_mon();
        @(posedge clk); #1 bus.START = 1'b1; bus.N = 8'd2;
        wait_done(20, ok1);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.START = 1'b0;
        wait_done(20, ok2);
        @(negedge clk);
        checks++;
        if (!ok1 || !ok2 || doneq.size() !== 2) begin
            errors++;
            $display("FAIL held_done: got ok=%b%b pulses=%0d want 11/2", ok1, ok2, doneq.size());
        end else begin
            checks++;
            if (doneq[1] - doneq[0] !== 4) begin
                errors++;
                $display("FAIL held_restart_gap: got %0d want 4", doneq[1] - doneq[0]);
            end
        end
        checks++;
        if (tq.size() !== 4 || tq[0] !== 0 || tq[1] !== 1 || tq[2] !== 0 || tq[3] !== 1) begin
            errors++;
            $display("FAIL held_terms: got count %0d want 0,1,0,1", tq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        logic [31:0] exp5 [5] = '{0, 1, 1, 2, 3};
        start_run(5);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ADD_IEA === 1'b1) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {bus.BUSY, bus.TERM, bus.TERM_VALID, bus.IDX, bus.OVF,
                      bus.ADD_A, bus.ADD_B, bus.ADD_IEA, bus.ADD_IEB} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got seen=%b busy=%b term=%h ie=%b want 1/0/0/0",
                     seen, bus.BUSY, bus.TERM, bus.ADD_IEA);
        end
        clear_mon();
        @(posedge clk); #1 rst_n = 1'b1;
        bus.START = 1'b1; bus.N = 8'd5;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1 bus.START = 1'b0;
        wait_done(100, ok);
        @(negedge clk);
        checks++;
        if (!ok || doneq.size() !== 1 || doneq[0] - start_cyc !== 19) begin
            errors++;
            $display("FAIL midreset_done: got ok=%b pulses=%0d want 1 pulse at +19", ok, doneq.size());
        end
        checks++;
        if (tq.size() !== 5) begin
            errors++;
            $display("FAIL midreset_count: got %0d want 5", tq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (tq[k] !== exp5[k] || iq[k] !== k) begin
                    errors++;
                    $display("FAIL midreset_term%0d: got %0d want %0d", k, tq[k], exp5[k]);
                end
            end
        end
        checks++;
        if (ie_bad !== 0 || ab_bad !== 0 || ieq.size() !== 3) begin
            errors++;
            $display("FAIL midreset_strobes: got ie_bad=%0d ab_bad=%0d n=%0d want 0/0/3", ie_bad, ab_bad, ieq.size());
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_n10();
        test_short();
        test_wrap8();
        test_start_ignored();
        test_start_held();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog");
    end

endmodule
